api_ext_port_master: RTL and testbench
======================================

# api_ext_port_master

Host-side driver for the api_extension I/O port. It turns single-cycle register-bus requests from network_path_shared into the port's command/status handshake. It waits for completion, returns read data with a one-cycle acknowledge and an error flag, and enforces the idle gap between transactions. An optional timeout aborts transactions that do not complete.

## Interface
- HOLD_CYCLES, 3: cycles command is held at IDLE after completion before the next request is accepted; minimum 2.
- TIMEOUT_CYCLES, 1024: cycles from issue to forced abort (only with the timeout feature); minimum 16.
- clk  in  1  clock.
- reset  in  1  reset, asynchronous, active-high.
- host_cs  in  1  request strobe; sampled only when host_busy is low.
- host_we  in  1  1 = write, 0 = read; sampled with host_cs.
- host_address  in  32  target address; sampled with host_cs.
- host_write_data  in  32  write data; sampled with host_cs.
- host_busy  out  1  transaction in flight or idle gap running.
- host_ack  out  1  one-cycle completion pulse.
- host_error  out  1  valid with host_ack; 1 = port ERROR or timeout.
- host_timeout  out  1  valid with host_ack; 1 = timeout abort.
- host_read_data  out  32  result; valid from host_ack until the next host_ack.
- err_count  out  8  saturating count of errored transactions.
- command  out  2  port command: 0 IDLE, 1 READ, 3 WRITE.
- status  in  2  port status: 0 BUSY, 1 READY, 3 ERROR.
- address  out  32  port address.
- write_data  out  32  port write data.
- read_data  in  32  port read data.

## Operation
- States: IDLE, ISSUE, WAIT, RELEASE.
- IDLE:
  - On host_cs, register address, write_data and host_we.
  - Set command to WRITE if host_we, otherwise READ.
  - Clear the timeout counter and go to ISSUE.
  - host_busy is 0 only in IDLE.
- ISSUE: wait for status == BUSY, then go to WAIT. READY or ERROR seen here is stale and is ignored.
- WAIT, status READY:
  - Capture read_data into host_read_data; pulse host_ack with host_error=0.
  - Set command to IDLE, load the hold counter and go to RELEASE.
- WAIT, status ERROR: same as READY, but host_error=1 and err_count increments (saturates at 0xff).
- RELEASE: command stays IDLE; count HOLD_CYCLES, then go to IDLE.
- Writes: host_read_data still captures read_data; the host ignores it.
- Timeout abort (feature on): if the counter reaches TIMEOUT_CYCLES-1 in ISSUE or WAIT:
  - host_read_data = 0xdeaddead.
  - Pulse host_ack with host_error=1 and host_timeout=1; err_count increments.
  - Set command to IDLE and go to RELEASE.
- Completion and timeout in the same cycle: completion wins.
- host_cs while busy is ignored and not queued.
- address and write_data hold their values until the next accepted request.

## Timing
- Reset values:
  - command IDLE, address 0, write_data 0.
  - host_busy 0, host_ack 0, host_error 0, host_timeout 0.
  - host_read_data 0, err_count 0; state IDLE.
- All outputs are registered; status and read_data are sampled directly.
- command changes the cycle after host_cs is accepted.
- host_ack is asserted the cycle after READY or ERROR is sampled in WAIT; command returns to IDLE in that same cycle.
- host_busy rises the cycle after acceptance and falls HOLD_CYCLES+1 cycles after host_ack.
- Back-to-back requests: minimum spacing from one host_ack to the next accepted host_cs is HOLD_CYCLES+1 cycles.
- Reset mid-transaction: command goes to IDLE asynchronously and no host_ack is issued. The downstream block recovers on its own command-idle path.

## Configuration
- API_EXT_PORT_MASTER_TIMEOUT_EN defined: timeout counter and abort path are present; host_timeout can assert.
- Undefined: ISSUE and WAIT wait indefinitely; host_timeout is tied to 0 and TIMEOUT_CYCLES is unused.

## Test plan
- Read 0x00000000 against a responder model of api_extension -> one host_ack, host_error=0, host_read_data=0x6170692d, host_busy drops HOLD_CYCLES+1 cycles after host_ack.
- Write 0x00000010 with 0x00000005, write 0x00000011 with 0x00000007, then read 0x00000012 -> three clean acks and read data 0x0000000c; second and third host_cs pulses issued while busy are ignored.
- Read 0x55000000 (unmapped prefix) -> host_error=1, host_read_data=0xdeaddead, err_count=1.
- Responder stuck at BUSY, macro defined, TIMEOUT_CYCLES=16 -> host_ack at cycle 16 after issue, host_timeout=1, command IDLE the same cycle; with macro undefined -> no host_ack after 1000 cycles.
- Assert reset while in WAIT -> command=0 immediately, no host_ack; after release a read of 0x00000002 returns 0x302e3230.
- 300 error transactions -> err_count saturates at 0xff.

Source files
------------

// File: rtl/api_ext_port_master_if.sv
// rtl/api_ext_port_master_if.sv - host register bus and api_extension port signal bundle
interface api_ext_port_master_if;
   logic        host_cs;
   logic        host_we;
   logic [31:0] host_address;
   logic [31:0] host_write_data;
   logic        host_busy;
   logic        host_ack;
   logic        host_error;
   logic        host_timeout;
   logic [31:0] host_read_data;
   logic [7:0]  err_count;
   logic [1:0]  command;
   logic [1:0]  status;
   logic [31:0] address;
   logic [31:0] write_data;
   logic [31:0] read_data;

   modport master (
      input  host_cs, host_we, host_address, host_write_data, status, read_data,
      output host_busy, host_ack, host_error, host_timeout, host_read_data, err_count,
             command, address, write_data
   );

   modport slave (
      output host_cs, host_we, host_address, host_write_data, status, read_data,
      input  host_busy, host_ack, host_error, host_timeout, host_read_data, err_count,
             command, address, write_data
   );
endinterface

// File: rtl/api_ext_port_master.sv
// rtl/api_ext_port_master.sv - turns host register requests into api_extension command/status handshakes
// Define API_EXT_PORT_MASTER_TIMEOUT_EN to build the timeout counter and abort path.
module api_ext_port_master #(
   parameter int unsigned HOLD_CYCLES    = 3,
   parameter int unsigned TIMEOUT_CYCLES = 1024
) (
   input  logic                  clk,
   input  logic                  reset,
   api_ext_port_master_if.master bus
);
   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RELEASE} state_t;

   localparam logic [1:0]  CMD_IDLE   = 2'd0;
   localparam logic [1:0]  CMD_READ   = 2'd1;
   localparam logic [1:0]  CMD_WRITE  = 2'd3;
   localparam logic [1:0]  ST_BUSY    = 2'd0;
   localparam logic [1:0]  ST_READY   = 2'd1;
   localparam logic [1:0]  ST_ERROR   = 2'd3;
   localparam logic [31:0] ABORT_DATA = 32'hdeaddead;
   localparam int unsigned HW         = $clog2(HOLD_CYCLES + 1);

   state_t        state;
   logic [HW-1:0] hold_cnt;
   logic          to_hit;
   logic          complete;
   logic          abort;
   logic          err_now;

`ifdef API_EXT_PORT_MASTER_TIMEOUT_EN
   localparam int unsigned TW = $clog2(TIMEOUT_CYCLES);
   logic [TW-1:0] to_cnt;

   // Counts only while a transaction is outstanding; IDLE clears it so every issue starts from zero.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         to_cnt <= '0;
      end else if (state == S_IDLE) begin
         to_cnt <= '0;
      end else if (state == S_ISSUE || state == S_WAIT) begin
         to_cnt <= to_cnt + 1'b1;
      end
   end

   assign to_hit = (state == S_ISSUE || state == S_WAIT) && (to_cnt == TW'(TIMEOUT_CYCLES - 1));
`else
   assign to_hit = 1'b0;
   // TIMEOUT_CYCLES has no effect in this build; the empty block only keeps the parameter referenced.
   if (TIMEOUT_CYCLES < 16) begin : g_timeout_unused
   end
`endif

   // A completion sampled in the same cycle as the timeout wins over the abort.
   always_comb begin
      complete = (state == S_WAIT) && (bus.status == ST_READY || bus.status == ST_ERROR);
      abort    = to_hit && !complete;
      err_now  = abort || (complete && bus.status == ST_ERROR);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state              <= S_IDLE;
         hold_cnt           <= '0;
         bus.command        <= CMD_IDLE;
         bus.address        <= '0;
         bus.write_data     <= '0;
         bus.host_busy      <= 1'b0;
         bus.host_ack       <= 1'b0;
         bus.host_error     <= 1'b0;
         bus.host_timeout   <= 1'b0;
         bus.host_read_data <= '0;
         bus.err_count      <= '0;
      end else begin
         bus.host_ack <= 1'b0;
         if (complete || abort) begin
            bus.host_ack       <= 1'b1;
            bus.host_error     <= err_now;
            bus.host_timeout   <= abort;
            bus.host_read_data <= abort ? ABORT_DATA : bus.read_data;
            bus.command        <= CMD_IDLE;
            hold_cnt           <= HW'(HOLD_CYCLES);
            state              <= S_RELEASE;
            if (err_now && bus.err_count != 8'hff) begin
               bus.err_count <= bus.err_count + 8'd1;
            end
         end else begin
            case (state)
               S_IDLE: begin
                  if (bus.host_cs) begin
                     bus.address    <= bus.host_address;
                     bus.write_data <= bus.host_write_data;
                     bus.command    <= bus.host_we ? CMD_WRITE : CMD_READ;
                     bus.host_busy  <= 1'b1;
                     state          <= S_ISSUE;
                  end
               end
               // READY/ERROR here is left over from the previous transaction.
               S_ISSUE: begin
                  if (bus.status == ST_BUSY) begin
                     state <= S_WAIT;
                  end
               end
               S_WAIT: begin
               end
               S_RELEASE: begin
                  if (hold_cnt == '0) begin
                     bus.host_busy <= 1'b0;
                     state         <= S_IDLE;
                  end else begin
                     hold_cnt <= hold_cnt - 1'b1;
                  end
               end
               default: state <= S_IDLE;
            endcase
         end
      end
   end
endmodule

// File: tb/tb_api_ext_port_master.sv
// tb/tb_api_ext_port_master.sv - randomized bench with api_extension responder and behavioural reference model
module tb_api_ext_port_master;
   localparam int HOLD = 3;
`ifdef API_EXT_PORT_MASTER_TIMEOUT_EN
   localparam int TMO = 16;
`else
   localparam int TMO = 1024;
`endif

   logic clk = 1'b0;
   logic reset = 1'b1;
   api_ext_port_master_if bus();

   api_ext_port_master #(.HOLD_CYCLES(HOLD), .TIMEOUT_CYCLES(TMO)) dut (
      .clk(clk), .reset(reset), .bus(bus)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] map_read(input logic [31:0] a, input logic [31:0] r10, input logic [31:0] r11);
      case (a)
         32'h0:   return 32'h6170692d;
         32'h1:   return 32'h6578742d;
         32'h2:   return 32'h302e3230;
         32'h10:  return r10;
         32'h11:  return r11;
         32'h12:  return r10 + r11;
         default: return 32'h0;
      endcase
   endfunction

   // responder state
   bit          stuck = 1'b0;
   int          r_phase, r_lat;
   logic [31:0] r_addr, r_wd, r_reg10 = 0, r_reg11 = 0;
   bit          r_we;
   bit          done_pend, to_pend;
   // reference model state
   bit          m_busy, m_inflight, exp_err, e_err, e_to, ack_exp, prev_busy;
   int          m_gap, to_age;
   logic [1:0]  m_cmd;
   logic [31:0] m_addr, m_wd, m_rdata, exp_rd, e_rd, m_reg10 = 0, m_reg11 = 0;
   logic [7:0]  m_err;
   int          pc = 0, cyc = 0, acc_pc, ack_pc, ack_cyc, fall_cyc, acks = 0, dut_acks = 0;
   logic [31:0] last_rd;
   logic        last_err, last_to;
   logic [1:0]  last_cmd;

   always begin
      @(posedge clk);
      pc++;
      if (!reset) begin
         if (m_inflight) begin
            to_age++;
`ifdef API_EXT_PORT_MASTER_TIMEOUT_EN
            if (to_age == TMO && !done_pend) to_pend = 1'b1;
`endif
         end
         if (bus.host_cs && !m_busy) begin
            m_busy = 1'b1; m_inflight = 1'b1; to_age = 0; acc_pc = pc;
            m_addr = bus.host_address; m_wd = bus.host_write_data;
            m_cmd = bus.host_we ? 2'd3 : 2'd1;
            if (m_addr[31:24] == 8'h55) begin
               exp_err = 1'b1; exp_rd = 32'hdeaddead;
            end else if (bus.host_we) begin
               exp_err = 1'b0; exp_rd = 32'h0;
               if (m_addr == 32'h10) m_reg10 = m_wd;
               if (m_addr == 32'h11) m_reg11 = m_wd;
            end else begin
               exp_err = 1'b0; exp_rd = map_read(m_addr, m_reg10, m_reg11);
            end
         end
      end
      @(negedge clk);
      cyc++;
      if (reset) begin
         r_phase = 0; done_pend = 0; to_pend = 0; bus.status = 2'd1; bus.read_data = 32'h0;
         m_busy = 0; m_inflight = 0; m_gap = 0; m_cmd = 0; m_addr = 0; m_wd = 0; m_rdata = 0;
         m_err = 0; prev_busy = 0;
      end else begin
         ack_exp = done_pend || to_pend;
         if (m_gap > 0) begin
            m_gap--;
            if (m_gap == 0) m_busy = 1'b0;
         end
         if (bus.host_ack === 1'b1) dut_acks++;
         chk("host_ack", bus.host_ack, ack_exp);
         if (ack_exp) begin
            if (done_pend) begin
               e_rd = exp_rd; e_err = exp_err; e_to = 1'b0;
            end else begin
               e_rd = 32'hdeaddead; e_err = 1'b1; e_to = 1'b1;
            end
            m_rdata = e_rd;
            if (e_err && m_err != 8'hff) m_err++;
            chk("host_error", bus.host_error, e_err);
            chk("host_timeout", bus.host_timeout, e_to);
            m_cmd = 2'd0; m_gap = HOLD + 1; m_inflight = 0; done_pend = 0; to_pend = 0;
            acks++; ack_pc = pc; ack_cyc = cyc;
            last_rd = bus.host_read_data; last_err = bus.host_error;
            last_to = bus.host_timeout; last_cmd = bus.command;
         end
         if (prev_busy && !bus.host_busy) fall_cyc = cyc;
         prev_busy = bus.host_busy;
         chk("host_busy", bus.host_busy, m_busy);
         chk("command", bus.command, m_cmd);
         chk("address", bus.address, m_addr);
         chk("write_data", bus.write_data, m_wd);
         chk("host_read_data", bus.host_read_data, m_rdata);
         chk("err_count", bus.err_count, m_err);
         case (r_phase)
            0: if (bus.command != 2'd0) begin
               r_phase = 1; bus.status = 2'd0;
               r_addr = bus.address; r_wd = bus.write_data; r_we = (bus.command == 2'd3);
               r_lat = $urandom_range(1, 4);
            end
            1: if (bus.command == 2'd0) begin
               r_phase = 0; bus.status = 2'd1;
            end else if (!stuck) begin
               r_lat--;
               if (r_lat == 0) begin
                  r_phase = 2; done_pend = 1'b1;
                  if (r_addr[31:24] == 8'h55) begin
                     bus.status = 2'd3; bus.read_data = 32'hdeaddead;
                  end else begin
                     bus.status = 2'd1;
                     if (r_we) begin
                        if (r_addr == 32'h10) r_reg10 = r_wd;
                        if (r_addr == 32'h11) r_reg11 = r_wd;
                        bus.read_data = 32'h0;
                     end else begin
                        bus.read_data = map_read(r_addr, r_reg10, r_reg11);
                     end
                  end
               end
            end
            default: if (bus.command == 2'd0) r_phase = 0;
         endcase
      end
   end

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic wait_idle();
      int n = 0;
      while (m_busy && n < 200) begin tick(); n++; end
      chk("idle_reached", {31'b0, m_busy}, 32'h0);
   endtask

   task automatic issue(input bit we, input logic [31:0] a, input logic [31:0] d);
      wait_idle();
      bus.host_cs = 1'b1; bus.host_we = we; bus.host_address = a; bus.host_write_data = d;
      tick();
      bus.host_cs = 1'b0;
   endtask

   task automatic do_txn(input bit we, input logic [31:0] a, input logic [31:0] d, input bit spam);
      int n = 0;
      int a0;
      a0 = acks;
      issue(we, a, d);
      while (acks == a0 && n < TMO + 300) begin
         if (spam && $urandom_range(0, 1) == 1) begin
            bus.host_cs = 1'b1; bus.host_we = 1'($urandom);
            bus.host_address = $urandom; bus.host_write_data = $urandom;
         end else begin
            bus.host_cs = 1'b0;
         end
         tick(); n++;
      end
      bus.host_cs = 1'b0;
      chk("txn_ack_seen", acks - a0, 32'd1);
   endtask

   initial begin
      int n0;
      logic [31:0] a;
      bus.host_cs = 1'b0; bus.host_we = 1'b0; bus.host_address = 0; bus.host_write_data = 0;
      tick(); tick();
      chk("rst_command", bus.command, 0);
      chk("rst_address", bus.address, 0);
      chk("rst_write_data", bus.write_data, 0);
      chk("rst_busy", bus.host_busy, 0);
      chk("rst_ack", bus.host_ack, 0);
      chk("rst_error", bus.host_error, 0);
      chk("rst_timeout", bus.host_timeout, 0);
      chk("rst_read_data", bus.host_read_data, 0);
      chk("rst_err_count", bus.err_count, 0);
      reset = 1'b0;
      tick();

      do_txn(1'b0, 32'h0, 32'h0, 1'b0);
      chk("id_read_data", last_rd, 32'h6170692d);
      chk("id_read_error", last_err, 1'b0);
      wait_idle();
      chk("busy_fall_after_ack", fall_cyc - ack_cyc, HOLD + 1);

      do_txn(1'b1, 32'h10, 32'h5, 1'b1);
      do_txn(1'b1, 32'h11, 32'h7, 1'b1);
      do_txn(1'b0, 32'h12, 32'h0, 1'b1);
      chk("sum_read_data", last_rd, 32'h0000000c);
      chk("sum_read_error", last_err, 1'b0);

      do_txn(1'b0, 32'h55000000, 32'h0, 1'b0);
      chk("unmapped_error", last_err, 1'b1);
      chk("unmapped_read_data", last_rd, 32'hdeaddead);
      chk("unmapped_err_count", bus.err_count, 8'd1);

      stuck = 1'b1;
`ifdef API_EXT_PORT_MASTER_TIMEOUT_EN
      do_txn(1'b0, 32'h0, 32'h0, 1'b0);
      chk("timeout_latency", ack_pc - acc_pc, 32'd16);
      chk("timeout_flag", last_to, 1'b1);
      chk("timeout_error", last_err, 1'b1);
      chk("timeout_read_data", last_rd, 32'hdeaddead);
      chk("timeout_command", last_cmd, 2'd0);
      issue(1'b0, 32'h1, 32'h0);
      repeat (6) tick();
`else
      n0 = dut_acks;
      issue(1'b0, 32'h1, 32'h0);
      repeat (1000) tick();
      chk("stuck_no_ack", dut_acks - n0, 0);
`endif
      chk("wait_command", bus.command, 2'd1);
      n0 = dut_acks;
      reset = 1'b1;
      #1;
      chk("reset_cmd_async", bus.command, 2'd0);
      chk("reset_busy_async", bus.host_busy, 1'b0);
      tick();
      stuck = 1'b0;
      tick();
      reset = 1'b0;
      tick();
      chk("reset_no_ack", dut_acks - n0, 0);
      do_txn(1'b0, 32'h2, 32'h0, 1'b0);
      chk("post_reset_read", last_rd, 32'h302e3230);

      for (int i = 0; i < 150; i++) begin
         case ($urandom_range(0, 6))
            0: a = 32'h0;
            1: a = 32'h1;
            2: a = 32'h2;
            3: a = 32'h10;
            4: a = 32'h11;
            5: a = 32'h12;
            default: a = {8'h55, 24'($urandom)};
         endcase
         repeat ($urandom_range(0, 7)) tick();
         do_txn(1'($urandom), a, $urandom, 1'($urandom));
      end

      for (int i = 0; i < 300; i++) begin
         do_txn(1'b0, {8'h55, 24'($urandom)}, 32'h0, 1'b0);
      end
      chk("err_count_saturated", bus.err_count, 8'hff);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #5ms;
      $display("FAIL watchdog actual=running required=finished");
      $fatal(1);
   end
endmodule
